// File: rtl/control_sequencer.sv
// Multi-cycle instruction control FSM (FETCH 000 | DECODE 001 | EXEC 010 | MEM 011 | WB 100).
// Memory waits in FETCH/MEM abort with mem_err after TIMEOUT cycles; the instruction is then refetched.
module control_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
    input  logic [4:0]  i_status,
    output logic        o_pc_we,
    output logic        o_pcsrc,
    output logic        o_ir_we,
    output logic        o_alusrc,
    output logic [3:0]  o_aluop,
    output logic [1:0]  o_immgen_ctrl,
    output logic        o_mem_req,
    output logic        o_memrw,
    output logic        o_wb,
    output logic        o_regrw,
    output logic        o_illegal,
    output logic        o_mem_err,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_ir;
    logic [7:0]  r_wait_cnt;
    logic        r_active;

    logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_legal;
    logic [2:0]  w_funct3;
    logic [3:0]  w_alu_fn;
    logic [1:0]  w_imm_fmt;
    logic        w_br_taken;
    logic        w_timeout;
    logic        w_mem_state;
    logic        w_unused_bits;

    assign w_funct3    = r_ir[14:12];
    assign w_is_r      = (r_ir[6:0] == OP_R);
    assign w_is_i      = (r_ir[6:0] == OP_I);
    assign w_is_ld     = (r_ir[6:0] == OP_LD);
    assign w_is_st     = (r_ir[6:0] == OP_ST);
    assign w_is_br     = (r_ir[6:0] == OP_BR);
    assign w_legal     = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br;
    assign w_br_taken  = ((w_funct3 == 3'b000) &&  i_status[4]) ||
                         ((w_funct3 == 3'b001) && !i_status[4]);
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM);
    // mem_ready in the terminal wait cycle still completes the access
    assign w_timeout   = (r_wait_cnt == WAIT_TC) && !i_mem_ready;
    assign w_unused_bits = ^{i_status[3:0], r_ir[31], r_ir[29:15], r_ir[11:7]};
    assign o_state     = r_state;

    always_comb begin
        w_alu_fn = 4'b0000;
        if (w_is_br) begin
            w_alu_fn = 4'b0001;
        end else if (w_is_r || w_is_i) begin
            case (w_funct3)
                3'b000:  w_alu_fn = (w_is_r && r_ir[30]) ? 4'b0001 : 4'b0000;
                3'b111:  w_alu_fn = 4'b0010;
                3'b110:  w_alu_fn = 4'b0011;
                3'b100:  w_alu_fn = 4'b0100;
                3'b010:  w_alu_fn = 4'b0101;
                3'b001:  w_alu_fn = 4'b0110;
                3'b101:  w_alu_fn = 4'b0111;
                default: w_alu_fn = 4'b0000;
            endcase
        end
    end

    always_comb begin
        w_imm_fmt = 2'b11;
        if (w_is_i || w_is_ld) w_imm_fmt = 2'b00;
        else if (w_is_st)      w_imm_fmt = 2'b01;
        else if (w_is_br)      w_imm_fmt = 2'b10;
    end

    always_comb begin
        w_state_next  = r_state;
        o_pc_we       = 1'b0;
        o_pcsrc       = 1'b0;
        o_ir_we       = 1'b0;
        o_alusrc      = 1'b0;
        o_aluop       = 4'b0000;
        o_immgen_ctrl = 2'b11;
        o_mem_req     = 1'b0;
        o_memrw       = 1'b0;
        o_wb          = 1'b0;
        o_regrw       = 1'b0;
        o_illegal     = 1'b0;
        o_mem_err     = 1'b0;
        // r_active holds everything idle for the first cycle after reset release
        if (r_active) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        o_ir_we      = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_timeout) begin
                        o_mem_req = 1'b0;
                        o_mem_err = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_state_next = S_EXEC;
                    end else begin
                        o_illegal    = 1'b1;
                        o_pc_we      = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
                S_EXEC: begin
                    o_alusrc      = !(w_is_r || w_is_br);
                    o_aluop       = w_alu_fn;
                    o_immgen_ctrl = w_imm_fmt;
                    if (w_is_br) begin
                        o_pc_we      = 1'b1;
                        o_pcsrc      = w_br_taken;
                        w_state_next = S_FETCH;
                    end else if (w_is_r || w_is_i) begin
                        w_state_next = S_WB;
                    end else begin
                        w_state_next = S_MEM;
                    end
                end
                S_MEM: begin
                    o_alusrc      = 1'b1;
                    o_aluop       = w_alu_fn;
                    o_immgen_ctrl = w_imm_fmt;
                    o_mem_req     = 1'b1;
                    o_memrw       = w_is_st;
                    if (i_mem_ready) begin
                        if (w_is_st) begin
                            o_pc_we      = 1'b1;
                            w_state_next = S_FETCH;
                        end else begin
                            w_state_next = S_WB;
                        end
                    end else if (w_timeout) begin
                        o_mem_req    = 1'b0;
                        o_memrw      = 1'b0;
                        o_mem_err    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
                S_WB: begin
                    o_regrw      = 1'b1;
                    o_pc_we      = 1'b1;
                    o_wb         = w_is_ld;
                    w_state_next = S_FETCH;
                end
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_FETCH;
            r_ir       <= 32'd0;
            r_wait_cnt <= 8'd0;
            r_active   <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_next;
            if (o_ir_we) r_ir <= i_instr;
            if (!r_active || !w_mem_state || i_mem_ready || w_timeout || (w_state_next != r_state))
                r_wait_cnt <= 8'd0;
            else
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver queues hand-computed expectations per instruction,
// the monitor pops one at each retire event (pc_we or mem_err) and compares what it observed.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_instr;
    logic        i_mem_ready;
    logic [4:0]  i_status;
    logic        o_pc_we, o_pcsrc, o_ir_we, o_alusrc;
    logic [3:0]  o_aluop;
    logic [1:0]  o_immgen_ctrl;
    logic        o_mem_req, o_memrw, o_wb, o_regrw, o_illegal, o_mem_err;
    logic [2:0]  o_state;

    control_sequencer #(.TIMEOUT(15)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_instr       (i_instr),
        .i_mem_ready   (i_mem_ready),
        .i_status      (i_status),
        .o_pc_we       (o_pc_we),
        .o_pcsrc       (o_pcsrc),
        .o_ir_we       (o_ir_we),
        .o_alusrc      (o_alusrc),
        .o_aluop       (o_aluop),
        .o_immgen_ctrl (o_immgen_ctrl),
        .o_mem_req     (o_mem_req),
        .o_memrw       (o_memrw),
        .o_wb          (o_wb),
        .o_regrw       (o_regrw),
        .o_illegal     (o_illegal),
        .o_mem_err     (o_mem_err),
        .o_state       (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] lat;
        logic [2:0] rstate;
        logic       pcsrc;
        logic [1:0] regrw;
        logic       wb;
        logic       ill;
        logic       merr;
        logic       pcwe;
        logic [1:0] irwe;
        logic       exec;
        logic [3:0] aluop;
        logic       alusrc;
        logic [1:0] imm;
        logic [1:0] ret_imm;
        logic       memrw;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    retired  = 0;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endfunction

    function automatic exp_t mk(input int lat, input int rstate, input bit pcsrc, input int regrw,
                                input bit wb, input bit ill, input bit merr, input bit pcwe,
                                input int irwe, input bit exec, input int aluop, input bit alusrc,
                                input int imm, input int ret_imm, input bit memrw);
        exp_t e;
        e.lat = 8'(lat);       e.rstate = 3'(rstate); e.pcsrc = pcsrc;     e.regrw = 2'(regrw);
        e.wb = wb;             e.ill = ill;           e.merr = merr;       e.pcwe = pcwe;
        e.irwe = 2'(irwe);     e.exec = exec;         e.aluop = 4'(aluop); e.alusrc = alusrc;
        e.imm = 2'(imm);       e.ret_imm = 2'(ret_imm); e.memrw = memrw;
        return e;
    endfunction

    // Monitor: accumulate per-instruction observations, compare at retire
    initial begin
        int         m_cyc, m_regrw, m_irwe, m_conf;
        bit         m_ill, m_exec, m_memrw;
        logic [3:0] m_aluop;
        logic       m_alusrc;
        logic [1:0] m_imm;
        exp_t       e;
        string      nm;
        m_cyc = 0; m_regrw = 0; m_irwe = 0; m_conf = 0;
        m_ill = 0; m_exec = 0; m_memrw = 0; m_aluop = 0; m_alusrc = 0; m_imm = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_cyc = 0; m_regrw = 0; m_irwe = 0; m_conf = 0;
                m_ill = 0; m_exec = 0; m_memrw = 0;
            end else begin
                if (o_state != 3'd0 || o_mem_req || o_mem_err) m_cyc++;
                if (o_regrw) m_regrw++;
                if (o_ir_we) m_irwe++;
                if (o_illegal) m_ill = 1;
                if (o_memrw) m_memrw = 1;
                if (o_regrw && o_memrw) m_conf++;
                if (o_state == 3'd2) begin
                    m_exec = 1; m_aluop = o_aluop; m_alusrc = o_alusrc; m_imm = o_immgen_ctrl;
                end
                if (o_pc_we || o_mem_err) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e  = sb.pop_front();
                        nm = nm_q.pop_front();
                        chk({nm, "_latency"},  m_cyc,         e.lat);
                        chk({nm, "_state"},    o_state,       e.rstate);
                        chk({nm, "_pcsrc"},    o_pcsrc,       e.pcsrc);
                        chk({nm, "_pc_we"},    o_pc_we,       e.pcwe);
                        chk({nm, "_mem_err"},  o_mem_err,     e.merr);
                        chk({nm, "_wb"},       o_wb,          e.wb);
                        chk({nm, "_ret_imm"},  o_immgen_ctrl, e.ret_imm);
                        chk({nm, "_regrw_n"},  m_regrw,       e.regrw);
                        chk({nm, "_ir_we_n"},  m_irwe,        e.irwe);
                        chk({nm, "_illegal"},  m_ill,         e.ill);
                        chk({nm, "_memrw"},    m_memrw,       e.memrw);
                        chk({nm, "_rw_clash"}, m_conf,        0);
                        chk({nm, "_exec"},     m_exec,        e.exec);
                        if (e.exec) begin
                            chk({nm, "_aluop"},  m_aluop,  e.aluop);
                            chk({nm, "_alusrc"}, m_alusrc, e.alusrc);
                            chk({nm, "_immgen"}, m_imm,    e.imm);
                        end
                    end
                    retired++;
                    m_cyc = 0; m_regrw = 0; m_irwe = 0; m_conf = 0;
                    m_ill = 0; m_exec = 0; m_memrw = 0;
                end
            end
        end
    end

    // Driver: called at posedge+1; fw/mw = mem_ready-low cycles in FETCH/MEM.
    // mem_ready is held high in non-memory states to show it is ignored there.
    task automatic run_instr(input string nm, input logic [31:0] ins, input int fw, input int mw,
                             input logic [4:0] st, input exp_t e);
        int start, nf, nmc;
        bit done;
        sb.push_back(e);
        nm_q.push_back(nm);
        i_instr = ins; i_status = st;
        start = retired; nf = 0; nmc = 0; done = 0;
        for (int k = 0; k < 64; k++) begin
            if (retired != start) begin
                done = 1;
                break;
            end
            if ((o_mem_req || o_mem_err) && o_state == 3'd0) begin
                i_mem_ready = (nf >= fw); nf++;
            end else if ((o_mem_req || o_mem_err) && o_state == 3'd3) begin
                i_mem_ready = (nmc >= mw); nmc++;
            end else if (o_state == 3'd0) begin
                i_mem_ready = 1'b0;
            end else begin
                i_mem_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_retired"}, done, 1);
        if (!done) begin
            sb.delete();
            nm_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},   o_state,       0);
        chk({tag, "_pc_we"},   o_pc_we,       0);
        chk({tag, "_pcsrc"},   o_pcsrc,       0);
        chk({tag, "_ir_we"},   o_ir_we,       0);
        chk({tag, "_alusrc"},  o_alusrc,      0);
        chk({tag, "_aluop"},   o_aluop,       0);
        chk({tag, "_immgen"},  o_immgen_ctrl, 3);
        chk({tag, "_mem_req"}, o_mem_req,     0);
        chk({tag, "_memrw"},   o_memrw,       0);
        chk({tag, "_wb"},      o_wb,          0);
        chk({tag, "_regrw"},   o_regrw,       0);
        chk({tag, "_illegal"}, o_illegal,     0);
        chk({tag, "_mem_err"}, o_mem_err,     0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [4:0] Z1 = 5'b10000;
    localparam logic [4:0] Z0 = 5'b00000;

    initial begin
        rst_n = 1'b1; i_instr = 32'd0; i_mem_ready = 1'b0; i_status = 5'd0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("release_idle_mem_req", o_mem_req, 0);
        @(posedge clk); #1;
        chk("release_fetch_mem_req", o_mem_req, 1);
        chk("release_fetch_state", o_state, 0);

        //         name         instr         fw   mw  status  lat st pcs rgw wb il me pcw irw ex aluop  src imm rim mrw
        run_instr("add",   32'h007302B3,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h0, 0, 3, 3, 0));
        run_instr("sub",   32'h40B50533,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h1, 0, 3, 3, 0));
        run_instr("xor",   32'h00C5C533,  1,   0, Z0, mk( 5, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h4, 0, 3, 3, 0));
        run_instr("and",   32'h00B57533,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h2, 0, 3, 3, 0));
        run_instr("slt",   32'h00B52533,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h5, 0, 3, 3, 0));
        run_instr("sll",   32'h00B51533,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h6, 0, 3, 3, 0));
        run_instr("sra",   32'h40B55533,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h7, 0, 3, 3, 0));
        run_instr("ori",   32'h00356513,  2,   0, Z0, mk( 6, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h3, 1, 0, 3, 0));
        run_instr("addi",  32'hFFF00093,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h0, 1, 0, 3, 0));
        run_instr("lw",    32'h0003AE03,  0,   2, Z0, mk( 7, 4, 0, 1, 1, 0, 0, 1, 1, 1, 4'h0, 1, 0, 3, 0));
        run_instr("sw",    32'h0063A023,  0,   0, Z0, mk( 4, 3, 0, 0, 0, 0, 0, 1, 1, 1, 4'h0, 1, 1, 1, 1));
        run_instr("sw_w",  32'h0063A023,  1,   1, Z0, mk( 6, 3, 0, 0, 0, 0, 0, 1, 1, 1, 4'h0, 1, 1, 1, 1));
        run_instr("beq_t", 32'h01C38F63,  0,   0, Z1, mk( 3, 2, 1, 0, 0, 0, 0, 1, 1, 1, 4'h1, 0, 2, 2, 0));
        run_instr("beq_n", 32'h01C38F63,  0,   0, Z0, mk( 3, 2, 0, 0, 0, 0, 0, 1, 1, 1, 4'h1, 0, 2, 2, 0));
        run_instr("bne_t", 32'h00B51463,  0,   0, Z0, mk( 3, 2, 1, 0, 0, 0, 0, 1, 1, 1, 4'h1, 0, 2, 2, 0));
        run_instr("bne_n", 32'h00B51463,  0,   0, Z1, mk( 3, 2, 0, 0, 0, 0, 0, 1, 1, 1, 4'h1, 0, 2, 2, 0));
        run_instr("blt_n", 32'h00B54463,  0,   0, Z1, mk( 3, 2, 0, 0, 0, 0, 0, 1, 1, 1, 4'h1, 0, 2, 2, 0));
        run_instr("illeg", 32'h0000007F,  0,   0, Z0, mk( 2, 1, 0, 0, 0, 1, 0, 1, 1, 0, 4'h0, 0, 3, 3, 0));
        run_instr("f_tmo", 32'h007302B3, 100,  0, Z0, mk(15, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 3, 3, 0));
        run_instr("f_edg", 32'h007302B3, 14,   0, Z0, mk(18, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h0, 0, 3, 3, 0));
        run_instr("m_tmo", 32'h0003AE03,  0, 100, Z0, mk(18, 3, 0, 0, 0, 0, 1, 0, 1, 1, 4'h0, 1, 0, 0, 0));
        run_instr("m_edg", 32'h0003AE03,  0,  14, Z0, mk(19, 4, 0, 1, 1, 0, 0, 1, 1, 1, 4'h0, 1, 0, 3, 0));

        // Reset asserted mid-MEM of a store: outputs must clear before the next edge
        i_instr = 32'h0063A023; i_status = Z0; i_mem_ready = 1'b1;
        @(posedge clk); #1 i_mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mem_pre_state", o_state, 3);
        chk("rst_mem_pre_memrw", o_memrw, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mem");
        @(posedge clk); #1 rst_n = 1'b1;
        chk("rst_mem_release_state", o_state, 0);
        chk("rst_mem_release_mem_req", o_mem_req, 0);
        @(posedge clk); #1;
        chk("rst_mem_fetch_mem_req", o_mem_req, 1);

        run_instr("add_r", 32'h007302B3,  0,   0, Z0, mk( 4, 4, 0, 1, 0, 0, 0, 1, 1, 1, 4'h0, 0, 3, 3, 0));

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
